// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of the byte-receive, register-write and response signals around
// the UART command-frame controller.
//
// Handshake rules:
//   rx_valid is a one-cycle strobe; rx_data is meaningful only while it is high
//   and there is no back-pressure on the receive side.
//   tx_valid/tx_ready is a strict valid/ready pair: once tx_valid rises,
//   tx_valid and tx_data stay stable until the cycle where tx_valid & tx_ready
//   are both high; that cycle is the transfer.
//   wr_en is a one-cycle strobe; wr_addr/wr_data hold their values between writes.
interface uart_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [7:0] err_cnt;

    // Controller side
    modport master (
        input  rx_data, rx_valid, tx_ready,
        output wr_en, wr_addr, wr_data, tx_data, tx_valid, busy, err_cnt
    );

    // Receiver / transmitter / register-file side
    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  wr_en, wr_addr, wr_data, tx_data, tx_valid, busy, err_cnt
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: hunts for the header byte, collects address, data
// and checksum, issues a one-cycle register write on a good frame, and returns
// one ACK/NAK byte. Stalled frames are abandoned after an inter-byte timeout;
// checksum failures and timeouts bump a saturating error counter.
module uart_cmd_ctrl #(
    parameter int         TIMEOUT_CYC = 104_166,
    parameter logic [7:0] HDR_BYTE    = 8'hA5,
    parameter logic [7:0] ACK_BYTE    = 8'h06,
    parameter logic [7:0] NAK_BYTE    = 8'h15
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_cmd_ctrl_if.master    bus,
    output logic [2:0]         dbg_state
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TERM_CNT = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic [7:0]    sum_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Frame FSM with inter-byte timeout; all outputs registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            sum_q        <= '0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            bus.err_cnt  <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (bus.rx_valid && bus.rx_data == HDR_BYTE) begin
                        sum_q <= HDR_BYTE;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // A received byte always beats the terminal count.
                    if (bus.rx_valid) begin
                        addr_q <= bus.rx_data;
                        sum_q  <= sum_q + bus.rx_data;
                        cnt    <= '0;
                        state  <= S_DATA;
                    end else if (cnt == TERM_CNT) begin
                        cnt         <= '0;
                        bus.err_cnt <= sat_inc(bus.err_cnt);
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        data_q <= bus.rx_data;
                        sum_q  <= sum_q + bus.rx_data;
                        cnt    <= '0;
                        state  <= S_CHK;
                    end else if (cnt == TERM_CNT) begin
                        cnt         <= '0;
                        bus.err_cnt <= sat_inc(bus.err_cnt);
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CHK: begin
                    if (bus.rx_valid) begin
                        cnt          <= '0;
                        bus.tx_valid <= 1'b1;
                        state        <= S_RESP;
                        if (bus.rx_data == sum_q) begin
                            bus.wr_addr <= addr_q;
                            bus.wr_data <= data_q;
                            bus.wr_en   <= 1'b1;
                            bus.tx_data <= ACK_BYTE;
                        end else begin
                            bus.tx_data <= NAK_BYTE;
                            bus.err_cnt <= sat_inc(bus.err_cnt);
                        end
                    end else if (cnt == TERM_CNT) begin
                        cnt         <= '0;
                        bus.err_cnt <= sat_inc(bus.err_cnt);
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    // Received bytes are dropped while the response is pending.
                    cnt <= '0;
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Busy and debug state are direct views of the state register.
    assign bus.busy  = (state != S_IDLE);
    assign dbg_state = state;

endmodule
